parity_sched: RTL
=================

// Module: parity_sched
// PURPOSE
//  Shares one xorTree parity reducer between NUM_REQ requesters. Round-robin arbiter picks one
//  valid request per cycle; word passes a 2-stage pipeline (capture reg -> xorTree -> result reg).
//  Response returns parity, requester id and mismatch flag vs. supplied expected parity.
//  Sits between memory/link clients and the shared parity datapath; throughput 1 word/cycle.
// PARAMETERS
//  NUM_REQ   4  number of requesters (2..16)
//  BIT_WIDTH 6  log2 of word width; WIDTH = 1<<BIT_WIDTH (64), matches xorTree BIT_WIDTH
//  ID_W      2  requester id width = $clog2(NUM_REQ)
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst          in   1              reset, synchronous, active-high
//  req_valid    in   NUM_REQ        per-requester word valid
//  req_ready    out  NUM_REQ        one-hot grant; handshake = req_valid[i] & req_ready[i]
//  req_data     in   NUM_REQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
//  req_exp_par  in   NUM_REQ        expected even-parity bit per requester
//  rsp_valid    out  1              result valid
//  rsp_ready    in   1              downstream accepts result
//  rsp_id       out  ID_W           requester index of result
//  rsp_par      out  1              XOR of all WIDTH bits of the word
//  rsp_err      out  1              rsp_par != captured expected parity
//  err_count    out  16             saturating error count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_par=0, rsp_err=0, err_count=0, rr_ptr=NUM_REQ-1,
//   both stage valids=0. Reset mid-operation drops in-flight words; no response emitted for them.
//  Stage S1 (capture): s1_valid,s1_id,s1_data,s1_exp. Stage S2 (result): drives rsp_* outputs.
//  stall = rsp_valid & ~rsp_ready. S2 loads when ~stall; S1 advances when ~stall | ~s1_valid.
//  Grant: when S1 can advance, req_ready = one-hot of first valid requester searching
//   rr_ptr+1, rr_ptr+2, ... wrapping modulo NUM_REQ; else req_ready=0. req_ready is
//   combinational from req_valid/state; requester must not depend on req_ready to raise valid.
//  rr_ptr <= granted index only on handshake; no request -> pointer holds.
//  Latency: handshake at cycle N -> rsp_valid=1 at N+2 (no stall). Back-to-back accepted.
//  Stall: S2 holds all rsp_* stable; S1 holds if full; no grants while S1 full and stalled.
//  S2 load with s1_valid=0 clears rsp_valid (bubble). rsp_valid&rsp_ready with new S1 word
//   -> next word presented next cycle, no bubble.
//  rsp_par = ^s1_data computed by xorTree combinationally between S1 and S2; rsp_err registered.
//  Single requester continuously valid gets every cycle; all valid -> strict rotation 0,1,2,3,...
// CONFIGURATION
//  PARITY_SCHED_ERRCNT_EN defined: err_count increments by 1 on each rsp_valid&rsp_ready with
//   rsp_err=1; saturates at 16'hFFFF; cleared only by rst.
//  Not defined: counter logic omitted, err_count tied to 16'h0000.
// STRUCTURE
//  parity_sched_pkg: WIDTH localparam function of BIT_WIDTH, id typedef, COUNT_MAX constant.
//  Sub-module parity_rr_arb: rr_ptr register + rotate-priority encoder (req, enable -> one-hot
//   grant, index); rr_ptr update on handshake. Top holds S1/S2 regs, stall logic, counter,
//   and one existing xorTree instance (BIT_WIDTH passed through).
// TESTING
//  1 Req0 only, data=64'h1, exp=0, rsp_ready=1 -> rsp at +2 cycles: id=0, par=1, err=1.
//  2 All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; ids match order.
//  3 rsp_ready=0 for 5 cycles with 4 valid -> 2 words held (S1,S2), req_ready=0, rsp_* stable;
//    release -> held words drain in order, no loss or duplication.
//  4 Req2 only after grant to 3 -> rr_ptr wraps, req2 granted; data=64'hFFFF_FFFF_FFFF_FFFF,
//    exp=0 -> par=0, err=0.
//  5 Assert rst with both stages full -> next cycle rsp_valid=0, req_ready=0, err_count=0,
//    first post-reset grant goes to req0.
//  6 ERRCNT_EN: 3 erroring responses, one stalled 4 cycles -> err_count=3 (counts handshakes
//    only); preload near 16'hFFFF via forced state -> saturates.

Source files
------------

// File: rtl/parity_sched_pkg.sv
// Shared constants and types for the parity scheduler slice.
package parity_sched_pkg;

    localparam int unsigned NUM_REQ_DEF   = 4;
    localparam int unsigned BIT_WIDTH_DEF = 6;
    localparam int unsigned ID_W_DEF      = $clog2(NUM_REQ_DEF);
    localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

    typedef logic [ID_W_DEF-1:0] id_t;

    function automatic int unsigned word_width(input int unsigned bit_width);
        return 32'd1 << bit_width;
    endfunction

endpackage

// File: rtl/parity_rr_arb.sv
// Round-robin arbiter: rotating-priority one-hot grant starting after the last winner.
import parity_sched_pkg::*;

module parity_rr_arb #(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [ID_W-1:0]    idx_c_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;
    int unsigned     cand;

    // Search ptr+1, ptr+2, ... wrapping; first valid requester wins.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (en_i && !found && req_i[cand]) begin
                found         = 1'b1;
                gnt_c_o[cand] = 1'b1;
                idx_c_o       = ID_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) ptr_d = idx_c_o;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= ID_W'(NUM_REQ - 1);
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/xorTree.sv
// Combinational even-parity reducer over a 2**BIT_WIDTH bit word.
module xorTree #(
    parameter int unsigned BIT_WIDTH = 6
) (
    input  logic [(1<<BIT_WIDTH)-1:0] data_i,
    output logic                      parity_o
);

    assign parity_o = ^data_i;

endmodule

// File: rtl/parity_sched.sv
// Shares one xorTree between NUM_REQ requesters via a round-robin grant and a 2-stage pipeline.
// Optional saturating error counter enabled by PARITY_SCHED_ERRCNT_EN.
import parity_sched_pkg::*;

module parity_sched #(
    parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*word_width(BIT_WIDTH)-1:0] req_data,
    input  logic [NUM_REQ-1:0]                     req_exp_par,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [ID_W-1:0]                        rsp_id,
    output logic                                   rsp_par,
    output logic                                   rsp_err,
    output logic [15:0]                            err_count
);

    localparam int unsigned WIDTH = word_width(BIT_WIDTH);

    logic               s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic [WIDTH-1:0]   s1_data_q, s1_data_d;
    logic               s1_exp_q, s1_exp_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_par_q, rsp_par_d;
    logic               rsp_err_q, rsp_err_d;

    logic               stall;
    logic               s1_adv;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               s1_par;

    assign stall  = rsp_valid_q & ~rsp_ready;
    assign s1_adv = ~stall | ~s1_valid_q;

    // Grants suppressed during reset so req_ready reads 0 while rst is high.
    parity_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_valid),
        .en_i    (s1_adv & ~rst),
        .gnt_c_o (gnt),
        .idx_c_o (gnt_idx)
    );

    xorTree #(.BIT_WIDTH(BIT_WIDTH)) u_xor (
        .data_i   (s1_data_q),
        .parity_o (s1_par)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        s1_data_d   = s1_data_q;
        s1_exp_d    = s1_exp_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_par_d   = rsp_par_q;
        rsp_err_d   = rsp_err_q;
        if (s1_adv) begin
            s1_valid_d = |gnt;
            s1_id_d    = gnt_idx;
            s1_data_d  = req_data[32'(gnt_idx)*WIDTH +: WIDTH];
            s1_exp_d   = req_exp_par[gnt_idx];
        end
        if (!stall) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_id_d  = s1_id_q;
                rsp_par_d = s1_par;
                rsp_err_d = s1_par ^ s1_exp_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_data_q   <= '0;
            s1_exp_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_par_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_data_q   <= s1_data_d;
            s1_exp_q    <= s1_exp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_par_q   <= rsp_par_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_par   = rsp_par_q;
    assign rsp_err   = rsp_err_q;

`ifdef PARITY_SCHED_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Counts accepted erroring responses only; sticks at COUNT_MAX.
    always_comb begin
        err_count_d = err_count_q;
        if (rsp_valid_q && rsp_ready && rsp_err_q && (err_count_q != COUNT_MAX))
            err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_count_q <= 16'h0000;
        else     err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule
